bht_update_controller: RTL and testbench
========================================

Name: bht_update_controller

Overview:
- Sequences all writes into the 16-entry, 2-bit branch history table (BHT).
- After reset, sweeps every entry to a known counter state.
- Then accepts resolved-branch outcomes from EX/MEM into a small in-order queue.
- Drains the queue one entry per cycle: reads the current counter, applies 2-bit saturating update, writes back, honouring pipeline stall.

Parameters:
- INDEX_WIDTH, 4, BHT index width; table holds 2**INDEX_WIDTH entries.
- FIFO_DEPTH, 4, pending-update queue depth; must be a power of 2, at least 2.
- INIT_STATE, 2'b01, counter value written to every entry by the init sweep (weakly not-taken).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  pipeline stall; no table write in a stalled cycle
- upd_valid  in  1  resolved-branch update offered
- upd_ready  out  1  controller accepts the update this cycle
- upd_index  in  INDEX_WIDTH  BHT index of resolved branch
- upd_taken  in  1  branch outcome, 1 = taken
- bht_rd_index  out  INDEX_WIDTH  table read index for read-modify-write
- bht_rd_data  in  2  counter returned combinationally by table
- bht_load  out  1  table write enable
- bht_opcode  out  7  7'b1100011 while bht_load=1, else 7'b0
- bht_wr_index  out  INDEX_WIDTH  table write index
- bht_wr_data  out  2  counter value to write
- init_done  out  1  init sweep complete
- busy  out  1  sweeping, or queue non-empty

Behaviour:
- Reset (rst=1 at posedge):
  - state=INIT, sweep_ptr=0, queue emptied (head=tail=count=0).
  - init_done=0.
  - In the cycle after reset, outputs are bht_load=1 (unless stall), wr_index=0, wr_data=INIT_STATE, upd_ready=0.
- Reset mid-operation discards all queued updates and restarts the sweep at index 0.
- FSM states: INIT, RUN. There is no other state.
- INIT:
  - Each non-stalled cycle: bht_load=1, bht_wr_index=sweep_ptr, bht_wr_data=INIT_STATE, then sweep_ptr++.
  - A stalled cycle gives bht_load=0 and sweep_ptr holds.
  - After writing entry 2**INDEX_WIDTH-1, go to RUN. init_done=1 from the next cycle and stays 1 until rst.
  - upd_ready=0 throughout INIT. Upstream holds its update.
- RUN, enqueue:
  - upd_ready = (count < FIFO_DEPTH). Registered count only; a full queue does not accept in the same cycle it dequeues.
  - valid&&ready at posedge writes {upd_index, upd_taken} at tail. Tail wraps modulo FIFO_DEPTH.
- RUN, drain:
  - bht_rd_index = head index when count>0, else 0.
  - If count>0 and ~stall: bht_load=1, wr_index=head index, wr_data=sat(bht_rd_data, head taken). Head advances, with wrap.
  - If stall or count==0: bht_load=0; queue head holds.
- Saturating update:
  - taken: 11 stays 11, else +1.
  - not-taken: 00 stays 00, else -1.
- Latency: an update accepted at edge N is written at the earliest at the end of cycle N+1 (empty queue, no stall).
- Throughput: 1 write per non-stalled cycle.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Back-to-back updates to the same index are correct without forwarding. The table write lands at the edge, and the next cycle's combinational read sees the new value.
- Order is strictly FIFO. No coalescing, no drops.
- busy = (state==INIT) || (count!=0).

Optional Feature:
- Macro: BHT_STATS_EN.
- Defined, adds outputs:
  - stat_updates [15:0]: increments on every RUN-state table write.
  - stat_saturated [15:0]: increments when the written value equals the read value (counter already saturated).
- Both counters reset to 0 on rst and wrap 16'hFFFF→0. Sweep writes are not counted.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Init sweep:
  - Stimulus: rst for 1 cycle, stall=0.
  - Response: bht_load=1 on the 16 following cycles, wr_index 0..15, wr_data=01, upd_ready=0. Then init_done=1, busy=0.
- Stalled init:
  - Stimulus: stall=1 for 3 cycles at sweep_ptr=5.
  - Response: bht_load=0 for those cycles, index 5 rewritten after release. Sweep completes 3 cycles late.
- Single update:
  - Stimulus: in RUN, enqueue index 3 taken; table model holds 01.
  - Response: next cycle rd_index=3, load=1, wr_index=3, wr_data=10, opcode=1100011.
- Same-index burst:
  - Stimulus: 4 consecutive taken updates to index 5, starting at 01.
  - Response: writes 10, 11, 11, 11 on consecutive cycles. stat_saturated +2 when BHT_STATS_EN is defined.
- Full queue under stall:
  - Stimulus: stall=1, offer 5 updates.
  - Response: 4 accepted, upd_ready=0, 5th held. Release stall: one write per cycle in order; upd_ready=1 the cycle after the first dequeue.
- Reset mid-drain:
  - Stimulus: rst asserted with 3 entries queued.
  - Response: queue empty, init_done=0, sweep restarts at index 0. No queued update is ever written.

Source files
------------

// File: rtl/bht_update_controller.sv
`default_nettype none
// ============================================================================
// Module   : bht_update_controller
// Purpose  : Init sweep + queued read-modify-write updates of a 2-bit BHT.
//            Optional stats counters enabled with macro BHT_STATS_EN.
// Revision : 1.0
// ============================================================================
module bht_update_controller #(
   parameter int         INDEX_WIDTH = 4,
   parameter int         FIFO_DEPTH  = 4,
   parameter logic [1:0] INIT_STATE  = 2'b01
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   upd_valid,
   output logic                   upd_ready,
   input  logic [INDEX_WIDTH-1:0] upd_index,
   input  logic                   upd_taken,
   output logic [INDEX_WIDTH-1:0] bht_rd_index,
   input  logic [1:0]             bht_rd_data,
   output logic                   bht_load,
   output logic [6:0]             bht_opcode,
   output logic [INDEX_WIDTH-1:0] bht_wr_index,
   output logic [1:0]             bht_wr_data,
   output logic                   init_done,
`ifdef BHT_STATS_EN
   output logic [15:0]            stat_updates,
   output logic [15:0]            stat_saturated,
`endif
   output logic                   busy
);

   localparam int                     PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0]         FULL_COUNT    = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]         CNT_ONE       = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0]       PTR_ONE       = PTR_W'(1);
   localparam logic [INDEX_WIDTH-1:0] IDX_ONE       = INDEX_WIDTH'(1);
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX    = '1;
   localparam logic [6:0]             BRANCH_OPCODE = 7'b1100011;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]             state_q,     state_d;
   logic [INDEX_WIDTH-1:0] sweep_ptr_q, sweep_ptr_d;
   logic                   init_done_q, init_done_d;
   logic [PTR_W-1:0]       head_q,      head_d;
   logic [PTR_W-1:0]       tail_q,      tail_d;
   logic [PTR_W:0]         count_q,     count_d;
   // Each queue entry is {index, taken}.
   logic [INDEX_WIDTH:0]   fifo_q [FIFO_DEPTH];
   logic [INDEX_WIDTH:0]   fifo_d [FIFO_DEPTH];

   logic                   enq;
   logic                   deq;
   logic [INDEX_WIDTH:0]   head_entry;

   function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic taken);
      logic [1:0] nxt;
      nxt = cur;
      if (taken) begin
         if (cur != 2'b11) nxt = cur + 2'b01;
      end else begin
         if (cur != 2'b00) nxt = cur - 2'b01;
      end
      return nxt;
   endfunction

   assign upd_ready  = (state_q == ST_RUN) && (count_q < FULL_COUNT);
   assign enq        = upd_valid && upd_ready;
   assign deq        = (state_q == ST_RUN) && (count_q != '0) && !stall;
   assign head_entry = fifo_q[head_q];
   assign init_done  = init_done_q;
   assign busy       = (state_q == ST_INIT) || (count_q != '0);
   assign bht_opcode = bht_load ? BRANCH_OPCODE : 7'b0;

   always_comb begin
      state_d      = state_q;
      sweep_ptr_d  = sweep_ptr_q;
      init_done_d  = init_done_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      fifo_d       = fifo_q;
      bht_rd_index = '0;
      bht_load     = 1'b0;
      bht_wr_index = '0;
      bht_wr_data  = 2'b00;

      case (state_q)
         ST_INIT: begin
            if (!stall) begin
               bht_load     = 1'b1;
               bht_wr_index = sweep_ptr_q;
               bht_wr_data  = INIT_STATE;
               sweep_ptr_d  = sweep_ptr_q + IDX_ONE;
               if (sweep_ptr_q == LAST_INDEX) begin
                  state_d     = ST_RUN;
                  init_done_d = 1'b1;
               end
            end
         end
         default: begin
            if (count_q != '0) begin
               bht_rd_index = head_entry[INDEX_WIDTH:1];
            end
            if (deq) begin
               bht_load     = 1'b1;
               bht_wr_index = head_entry[INDEX_WIDTH:1];
               bht_wr_data  = sat_update(bht_rd_data, head_entry[0]);
               head_d       = head_q + PTR_ONE;
            end
         end
      endcase

      if (enq) begin
         fifo_d[tail_q] = {upd_index, upd_taken};
         tail_d         = tail_q + PTR_ONE;
      end

      // Simultaneous enqueue and dequeue leaves the occupancy unchanged.
      case ({enq, deq})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         sweep_ptr_q <= '0;
         init_done_q <= 1'b0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         sweep_ptr_q <= sweep_ptr_d;
         init_done_q <= init_done_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
      end
   end

   // Queue storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

`ifdef BHT_STATS_EN
   logic [15:0] stat_updates_q,   stat_updates_d;
   logic [15:0] stat_saturated_q, stat_saturated_d;

   always_comb begin
      stat_updates_d   = stat_updates_q;
      stat_saturated_d = stat_saturated_q;
      if (deq) begin
         stat_updates_d = stat_updates_q + 16'd1;
         if (bht_wr_data == bht_rd_data) begin
            stat_saturated_d = stat_saturated_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_updates_q   <= '0;
         stat_saturated_q <= '0;
      end else begin
         stat_updates_q   <= stat_updates_d;
         stat_saturated_q <= stat_saturated_d;
      end
   end

   assign stat_updates   = stat_updates_q;
   assign stat_saturated = stat_saturated_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bht_update_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_bht_update_controller
// Purpose  : Self-checking bench with a behavioural table and a write scoreboard.
// Revision : 1.0
// ============================================================================
module tb_bht_update_controller;

   typedef struct {
      logic [3:0] idx;
      logic       tkn;
      logic [1:0] data;
   } vec_t;

   typedef struct {
      logic [3:0] idx;
      logic [1:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       stall;
   logic       upd_valid;
   logic       upd_ready;
   logic [3:0] upd_index;
   logic       upd_taken;
   logic [3:0] bht_rd_index;
   logic [1:0] bht_rd_data;
   logic       bht_load;
   logic [6:0] bht_opcode;
   logic [3:0] bht_wr_index;
   logic [1:0] bht_wr_data;
   logic       init_done;
   logic       busy;
`ifdef BHT_STATS_EN
   logic [15:0] stat_updates;
   logic [15:0] stat_saturated;
`endif

   logic [1:0] tb_mem [16];
   exp_t       exp_q[$];
   exp_t       cur_exp;
   bit         run_mode;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   bht_update_controller #(
      .INDEX_WIDTH (4),
      .FIFO_DEPTH  (4),
      .INIT_STATE  (2'b01)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .upd_valid      (upd_valid),
      .upd_ready      (upd_ready),
      .upd_index      (upd_index),
      .upd_taken      (upd_taken),
      .bht_rd_index   (bht_rd_index),
      .bht_rd_data    (bht_rd_data),
      .bht_load       (bht_load),
      .bht_opcode     (bht_opcode),
      .bht_wr_index   (bht_wr_index),
      .bht_wr_data    (bht_wr_data),
      .init_done      (init_done),
`ifdef BHT_STATS_EN
      .stat_updates   (stat_updates),
      .stat_saturated (stat_saturated),
`endif
      .busy           (busy)
   );

   // Behavioural table: combinational read, write at the clock edge.
   assign bht_rd_data = tb_mem[bht_rd_index];
   always @(posedge clk) begin
      if (bht_load) tb_mem[bht_wr_index] <= bht_wr_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One clock: scoreboard check at negedge, acceptance captured at posedge.
   task automatic step(output bit acc, output bit ld);
      exp_t e;
      @(negedge clk);
      ld  = bht_load;
      acc = upd_valid && upd_ready;
      if (run_mode && bht_load) begin
         chk("write_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_index", bht_wr_index, e.idx);
            chk("rd_index", bht_rd_index, e.idx);
            chk("wr_data", bht_wr_data, e.data);
            chk("opcode", bht_opcode, 7'b1100011);
         end
      end
      @(posedge clk);
      if (acc) exp_q.push_back(cur_exp);
      #1;
   endtask

   task automatic do_sweep(input int stall_at, input int nstall);
      int ptr = 0;
      int st  = 0;
      int cyc = 0;
      while (ptr < 16 && cyc < 40) begin
         stall = (ptr == stall_at && st < nstall);
         @(negedge clk);
         if (stall) begin
            chk("init_stall_load", bht_load, 0);
            st++;
         end else begin
            chk("init_load", bht_load, 1);
            chk("init_wr_index", bht_wr_index, ptr);
            chk("init_wr_data", bht_wr_data, 2'b01);
            chk("init_opcode", bht_opcode, 7'b1100011);
            ptr++;
         end
         chk("init_ready", upd_ready, 0);
         chk("init_done_low", init_done, 0);
         chk("init_busy", busy, 1);
         @(posedge clk);
         #1;
         cyc++;
      end
      stall = 1'b0;
      chk("sweep_cycles", cyc, 16 + nstall);
      @(negedge clk);
      chk("post_init_done", init_done, 1);
      chk("post_init_busy", busy, 0);
      chk("post_init_load", bht_load, 0);
      chk("post_init_ready", upd_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [3:0] idx, input logic tkn, input logic [1:0] data);
      upd_valid    = 1'b1;
      upd_index    = idx;
      upd_taken    = tkn;
      cur_exp.idx  = idx;
      cur_exp.data = data;
   endtask

   initial begin
      vec_t vecs [11];
      bit   acc;
      bit   ld;

      vecs[0]  = '{4'd5,  1'b1, 2'b10};
      vecs[1]  = '{4'd5,  1'b1, 2'b11};
      vecs[2]  = '{4'd5,  1'b1, 2'b11};
      vecs[3]  = '{4'd5,  1'b1, 2'b11};
      vecs[4]  = '{4'd5,  1'b0, 2'b10};
      vecs[5]  = '{4'd0,  1'b0, 2'b00};
      vecs[6]  = '{4'd0,  1'b0, 2'b00};
      vecs[7]  = '{4'd15, 1'b1, 2'b10};
      vecs[8]  = '{4'd3,  1'b1, 2'b11};
      vecs[9]  = '{4'd3,  1'b0, 2'b10};
      vecs[10] = '{4'd7,  1'b0, 2'b00};

      rst       = 1'b1;
      stall     = 1'b0;
      upd_valid = 1'b0;
      upd_index = '0;
      upd_taken = 1'b0;
      run_mode  = 1'b0;
      cur_exp   = '{4'd0, 2'b00};

      // Plain sweep after reset.
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_sweep(-1, 0);

      // Sweep with a 3-cycle stall at index 5.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_sweep(5, 3);
`ifdef BHT_STATS_EN
      chk("stat_updates_reset", stat_updates, 0);
      chk("stat_saturated_reset", stat_saturated, 0);
`endif
      run_mode = 1'b1;

      // Single update: written the cycle after acceptance.
      offer(4'd3, 1'b1, 2'b10);
      step(acc, ld);
      chk("single_accept", acc, 1);
      upd_valid = 1'b0;
      step(acc, ld);
      chk("single_latency_load", ld, 1);

      // Table-driven back-to-back updates.
      for (int i = 0; i < 11; i++) begin
         offer(vecs[i].idx, vecs[i].tkn, vecs[i].data);
         step(acc, ld);
         chk("vec_accept", acc, 1);
      end
      upd_valid = 1'b0;
      for (int i = 0; i < 3; i++) step(acc, ld);
      chk("vec_drained", exp_q.size(), 0);
      chk("vec_idle_busy", busy, 0);
`ifdef BHT_STATS_EN
      chk("stat_updates", stat_updates, 12);
      chk("stat_saturated", stat_saturated, 3);
`endif

      // Full queue under stall.
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         offer(4'(8 + k), 1'b1, 2'b10);
         step(acc, ld);
         chk("full_accept", acc, 1);
      end
      offer(4'd12, 1'b1, 2'b10);
      for (int k = 0; k < 2; k++) begin
         step(acc, ld);
         chk("full_held", acc, 0);
         chk("full_stall_load", ld, 0);
      end
      stall = 1'b0;
      step(acc, ld);
      chk("full_first_deq_load", ld, 1);
      chk("full_ready_same_cycle", acc, 0);
      step(acc, ld);
      chk("full_ready_next_cycle", acc, 1);
      upd_valid = 1'b0;
      for (int i = 0; i < 6; i++) step(acc, ld);
      chk("full_drained", exp_q.size(), 0);

      // Reset with three updates still queued.
      stall = 1'b1;
      offer(4'd1, 1'b1, 2'b10);
      step(acc, ld);
      offer(4'd2, 1'b1, 2'b10);
      step(acc, ld);
      offer(4'd4, 1'b0, 2'b00);
      step(acc, ld);
      upd_valid = 1'b0;
      chk("mid_queued", exp_q.size(), 3);
      run_mode = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      stall = 1'b0;
      exp_q.delete();
      do_sweep(-1, 0);
      run_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(acc, ld);
         chk("mid_no_stale_write", ld, 0);
      end
      chk("mid_entry1", tb_mem[1], 2'b01);
      chk("mid_entry4", tb_mem[4], 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
